// File: rtl/pipel_result_fifo_if.sv
// Handshake bundle between the arithmetic pipeline, the result FIFO and its consumer.
interface pipel_result_fifo_if #(
  parameter int N = 20
) ();
  logic         in_valid;
  logic [N-1:0] pipe_f;
  logic [N-1:0] out_data;
  logic         out_valid;
  logic         out_ready;

  modport master (
    output in_valid, pipe_f, out_ready,
    input  out_data, out_valid
  );

  modport slave (
    input  in_valid, pipe_f, out_ready,
    output out_data, out_valid
  );
endinterface

// File: rtl/pipel_result_fifo.sv
// Captures results of the non-stalling pipel pipeline into a small FIFO with a valid/ready output.
// Optional feature macro: PIPEL_RESULT_DROP_CNT_EN builds the saturating drop counter.
module pipel_result_fifo #(
  parameter int N       = 20,
  parameter int LATENCY = 5,
  parameter int DEPTH   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  pipel_result_fifo_if.slave       bus,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  input  logic                     clr_ovf,
  output logic [7:0]               drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [LATENCY-1:0] vld_sr;
  logic [N-1:0]       mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic               cap;
  logic               push;
  logic               pop;
  logic               drop;

  assign cap  = vld_sr[LATENCY-1];
  assign full = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign pop  = bus.out_valid & bus.out_ready;
  assign push = cap & (~full | pop);
  assign drop = cap & full & ~pop;

  assign bus.out_valid = ~empty;
  assign bus.out_data  = mem[rd_ptr];

  // Valid delay line: mirrors the pipeline latency so cap lines up with pipe_f
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_sr <= '0;
    end else begin
      vld_sr[0] <= bus.in_valid;
      for (int i = 1; i < LATENCY; i++) begin
        vld_sr[i] <= vld_sr[i-1];
      end
    end
  end

  // FIFO storage and pointers; full/empty come from count, so pointers just wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= bus.pipe_f;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Drop reporting: a drop in the same cycle as a clear takes priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

`ifdef PIPEL_RESULT_DROP_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= 8'd0;
    end else if (drop && clr_ovf) begin
      drop_cnt <= 8'd1;
    end else if (clr_ovf) begin
      drop_cnt <= 8'd0;
    end else if (drop && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end
`else
  assign drop_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_pipel_result_fifo.sv
// Scoreboard bench for pipel_result_fifo: a stand-in pipeline feeds pipe_f, a monitor checks every pop.
module tb_pipel_result_fifo;

  localparam int N       = 20;
  localparam int LATENCY = 5;
  localparam int DEPTH   = 8;
`ifdef PIPEL_RESULT_DROP_CNT_EN
  localparam int DC_EN = 1;
`else
  localparam int DC_EN = 0;
`endif

  logic                  clk;
  logic                  rst_n;
  logic                  clr_ovf;
  logic [$clog2(DEPTH):0] count;
  logic                  full;
  logic                  empty;
  logic                  overflow;
  logic [7:0]            drop_cnt;

  pipel_result_fifo_if #(.N(N)) intf ();

  pipel_result_fifo #(.N(N), .LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (intf.slave),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .overflow (overflow),
    .clr_ovf  (clr_ovf),
    .drop_cnt (drop_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [N-1:0] sb [$];
  logic [N-1:0] hist [LATENCY+1];
  int unsigned  junk = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, got running required finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted output must match the oldest expected result
  always @(negedge clk) begin
    if (rst_n && intf.out_valid && intf.out_ready) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_pop: got %0h, required no output", intf.out_data);
      end else begin
        logic [N-1:0] e;
        e = sb.pop_front();
        if (intf.out_data !== e) begin
          n_bad++;
          $display("FAIL pop_data: got %0h, required %0h", intf.out_data, e);
        end
      end
    end
  end

  // One clock: present operand (valid + value), model pipeline delay onto pipe_f
  task automatic cyc(input logic v, input logic [N-1:0] d);
    intf.in_valid = v;
    for (int k = LATENCY; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = v ? d : (20'hF0000 + N'(junk));
    junk++;
    intf.pipe_f = hist[LATENCY];
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0);
  endtask

  task automatic drain(input string name);
    intf.out_ready = 1'b1;
    for (int i = 0; i < 4 * DEPTH && !empty; i++) cyc(1'b0, '0);
    chk(name, {31'd0, empty}, 32'd1);
    chk({name, "_sb"}, sb.size(), 32'd0);
    intf.out_ready = 1'b0;
  endtask

  initial begin
    for (int k = 0; k <= LATENCY; k++) hist[k] = '0;
    rst_n          = 1'b0;
    clr_ovf        = 1'b0;
    intf.in_valid  = 1'b0;
    intf.pipe_f    = '0;
    intf.out_ready = 1'b0;
    idle(3);

    // Reset state
    chk("rst_out_valid", {31'd0, intf.out_valid}, 32'd0);
    chk("rst_out_data",  intf.out_data, 32'd0);
    chk("rst_empty",     {31'd0, empty}, 32'd1);
    chk("rst_full",      {31'd0, full}, 32'd0);
    chk("rst_count",     count, 32'd0);
    chk("rst_overflow",  {31'd0, overflow}, 32'd0);
    chk("rst_drop_cnt",  drop_cnt, 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Latency alignment: single pulse appears exactly LATENCY edges later
    cyc(1'b1, 20'h00ABC);
    sb.push_back(20'h00ABC);
    idle(LATENCY - 1);
    chk("lat_early_valid", {31'd0, intf.out_valid}, 32'd0);
    idle(1);
    chk("lat_valid", {31'd0, intf.out_valid}, 32'd1);
    chk("lat_data",  intf.out_data, 32'h00ABC);
    chk("lat_count", count, 32'd1);
    idle(3);
    chk("lat_single_entry", count, 32'd1);
    drain("lat_drain");

    // Burst of 8 with consumer stalled
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, N'(i));
      sb.push_back(N'(i));
    end
    idle(LATENCY);
    chk("burst_full",  {31'd0, full}, 32'd1);
    chk("burst_count", count, 32'd8);
    chk("burst_ovf",   {31'd0, overflow}, 32'd0);
    drain("burst_drain");

    // Overflow: fill, then three dropped captures
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, 20'h00100 + N'(i));
      sb.push_back(20'h00100 + N'(i));
    end
    for (int i = 1; i <= 3; i++) cyc(1'b1, 20'h00200 + N'(i));
    idle(LATENCY);
    chk("ovf_count",    count, 32'd8);
    chk("ovf_head",     intf.out_data, 32'h00101);
    chk("ovf_flag",     {31'd0, overflow}, 32'd1);
    chk("ovf_drop_cnt", drop_cnt, DC_EN ? 32'd3 : 32'd0);
    clr_ovf = 1'b1;
    idle(1);
    clr_ovf = 1'b0;
    chk("clr_flag",     {31'd0, overflow}, 32'd0);
    chk("clr_drop_cnt", drop_cnt, 32'd0);

    // Full with simultaneous pop: ready rises exactly as captures arrive
    for (int i = 9; i <= 11; i++) begin
      cyc(1'b1, 20'h00100 + N'(i));
      sb.push_back(20'h00100 + N'(i));
    end
    idle(LATENCY - 3);
    intf.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle(1);
      chk("fullpop_count", count, 32'd8);
      chk("fullpop_ovf",   {31'd0, overflow}, 32'd0);
    end
    drain("fullpop_drain");

    // Saturation: fill, 300 drops
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, 20'h00400 + N'(i));
      sb.push_back(20'h00400 + N'(i));
    end
    for (int i = 0; i < 300; i++) cyc(1'b1, 20'h0DDDD);
    idle(LATENCY);
    chk("sat_drop_cnt", drop_cnt, DC_EN ? 32'd255 : 32'd0);
    chk("sat_ovf",      {31'd0, overflow}, 32'd1);
    chk("sat_count",    count, 32'd8);
    cyc(1'b1, 20'h0EEEE);
    idle(LATENCY - 1);
    clr_ovf = 1'b1;
    idle(1);
    clr_ovf = 1'b0;
    chk("clrdrop_ovf",      {31'd0, overflow}, 32'd1);
    chk("clrdrop_drop_cnt", drop_cnt, DC_EN ? 32'd1 : 32'd0);
    drain("sat_drain");

    // Reset mid-operation: held and in-flight results both vanish
    cyc(1'b1, 20'h00301);
    cyc(1'b1, 20'h00302);
    sb.push_back(20'h00301);
    sb.push_back(20'h00302);
    idle(LATENCY);
    chk("pre_rst_count", count, 32'd2);
    cyc(1'b1, 20'h003F1);
    cyc(1'b1, 20'h003F2);
    idle(1);
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("midrst_valid",    {31'd0, intf.out_valid}, 32'd0);
    chk("midrst_count",    count, 32'd0);
    chk("midrst_data",     intf.out_data, 32'd0);
    chk("midrst_ovf",      {31'd0, overflow}, 32'd0);
    idle(2);
    rst_n = 1'b1;
    intf.out_ready = 1'b1;
    idle(2 * LATENCY);
    chk("postrst_valid", {31'd0, intf.out_valid}, 32'd0);
    chk("postrst_count", count, 32'd0);
    chk("final_sb",      sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipel_result_fifo.md
# pipel_result_fifo

Result-capture stage placed directly downstream of the 3-stage arithmetic pipeline (`pipel`). The pipeline cannot stall, so this block does three things:
- tracks which operand sets were valid, using a delay line matched to the pipeline latency;
- captures the corresponding `f` results into a small FIFO;
- presents the results to a consumer over a valid/ready handshake.

It flags results dropped on overflow. `N` matches the pipeline operand/result width.

## Interface
Parameters:
- `N`, 20, data width; equals the pipeline `n`.
- `LATENCY`, 5, number of edges from sampling `in_valid` to sampling the matching `pipe_f`; must be ≥ 1.
- `DEPTH`, 8, FIFO entries; power of two, ≥ 2.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  qualifies the operand set presented to the pipeline inputs in the same cycle.
- `pipe_f`  in  N  pipeline result `f`.
- `out_data`  out  N  head-of-FIFO result.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  consumer accepts `out_data` when `out_valid` and `out_ready` are both high.
- `count`  out  $clog2(DEPTH)+1  current occupancy.
- `full`  out  1  `count == DEPTH`.
- `empty`  out  1  `count == 0`.
- `overflow`  out  1  sticky: at least one result was dropped.
- `clr_ovf`  in  1  synchronous clear of `overflow` (and `drop_cnt`).
- `drop_cnt`  out  8  saturating count of dropped results (see Configuration).

## Operation
- **Valid delay line.** `vld_sr[LATENCY-1:0]` takes `vld_sr[0] <= in_valid` and `vld_sr[i] <= vld_sr[i-1]` each edge. `cap = vld_sr[LATENCY-1]`.
- **Pop.** `pop = out_valid & out_ready`.
- **Push.** `push = cap & (~full | pop)`. On push, write `pipe_f` to `mem[wr_ptr]` and increment `wr_ptr` modulo `DEPTH`. On pop, increment `rd_ptr` modulo `DEPTH`.
- **Occupancy.** `count` goes up by 1 on push only, down by 1 on pop only, and is unchanged on both or neither.
- **Output.** `out_data = mem[rd_ptr]`, read combinationally from the register array. `out_valid = ~empty`.
- **Drop.** `drop = cap & full & ~pop`. On a drop:
  - `pipe_f` is discarded and FIFO contents are unchanged;
  - `overflow` sets;
  - `drop_cnt` increments, saturating at 255.
- **Clear.** `clr_ovf` clears `overflow` and `drop_cnt`. If `drop` occurs in the same cycle, set wins: `overflow = 1` and `drop_cnt = 1`.
- **Pointer wrap.** Pointers wrap silently. Full vs. empty is resolved by `count`, not by pointer comparison.
- **Arithmetic.** No arithmetic is applied to data. `pipe_f` is stored bit-exact at width `N`.

## Timing
- **Reset values** (all asynchronously cleared):
  - `vld_sr`, pointers, `count`, `overflow`, `drop_cnt`, and all `mem` entries = 0;
  - hence `out_data = 0`, `out_valid = 0`, `empty = 1`, `full = 0`.
- **Capture alignment.** `in_valid` sampled at edge t means `pipe_f` is captured at edge t+`LATENCY`.
- **Write-to-visibility.** A pushed entry becomes visible on `out_valid`/`out_data` immediately after the push edge. There is no same-cycle bypass from `pipe_f` to `out_data`.
- **Throughput.** Back-to-back `in_valid` is supported: one push per cycle, sustained.
- **Ready independence.** `out_ready` may be high with `out_valid` low; this has no effect. `out_valid` does not depend combinationally on `out_ready`.
- **Full with simultaneous pop.** Push and pop both occur, `count` stays at `DEPTH`, and nothing is dropped.
- **Empty with push.** There is no pop in that cycle; `out_valid` rises after the edge.
- **Reset mid-operation.** Results in flight inside the pipeline are discarded, because `vld_sr` is cleared. Results already held in the FIFO are lost.

## Configuration
- Macro: `PIPEL_RESULT_DROP_CNT_EN`.
- **Defined:** `drop_cnt` is an 8-bit saturating counter as described in Operation.
- **Undefined:** the `drop_cnt` port remains and is tied to 8'd0, and no counter logic is built. `overflow` behaves identically in both builds.

## Test plan
- **Reset.** Assert `rst_n = 0` mid-stream → all outputs at reset values; `in_valid` pulses issued within `LATENCY` cycles before reset never appear at the output.
- **Latency alignment.** `in_valid = 1` for one cycle at edge 10, with `pipe_f = 20'h00ABC` exactly during the cycle before edge 15 and other values elsewhere → exactly one entry, `out_data = 20'h00ABC`, `out_valid` high after edge 15.
- **Burst.** 8 consecutive valid inputs, results 1..8, `out_ready = 0` → `full = 1`, `count = 8`. Then `out_ready = 1` → outputs 1..8 in order, then `empty = 1`.
- **Overflow.** FIFO full, `out_ready = 0`, 3 further captures → contents unchanged, `overflow = 1`, `drop_cnt = 3` (0 without the macro). Pulse `clr_ovf` → both cleared.
- **Full with simultaneous pop.** FIFO full, `out_ready = 1`, continuous captures 9, 10, 11 → no drops, `count` stays 8, output order continues.
- **Saturation.** 300 drops → `drop_cnt = 255`. `clr_ovf` asserted together with a drop → `overflow = 1`, `drop_cnt = 1`.
